// File: rtl/scroll_scheduler.sv
// scroll_scheduler: frame-synchronous x/y scroll offsets advanced
// on vsync rising edges under RUN/PAUSE/STEP/STOP control.
module scroll_scheduler #(
  parameter int V_WRAP = 480,
  parameter int STEP_X = 1,
  parameter int STEP_Y = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic       frame_tick,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_STEP  = 2'b11
  } state_e;

  localparam logic [10:0] WRAP = 11'(V_WRAP);
  localparam logic [10:0] SY   = 11'(STEP_Y);
  localparam logic [9:0]  SX   = 10'(STEP_X);

  state_e     state_q, state_d, cmd;
  logic       q1_q, q2_q, arm_q;
  logic [2:0] pre_q, pre_d;
  logic [1:0] div_q, div_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic       en_y_q, en_y_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       tick_q, run_q, run_d;
  logic       frame_evt, do_step, pre_max;
  logic [9:0] x_step, y_step;
  logic [10:0] y_inc, y_dec;
  logic       unused_cfg;

  assign unused_cfg = cfg_data[7];
  assign cmd        = state_e'(cfg_data[1:0]);

  // arm_q records a low vsync sample since reset, so a vsync already
  // high at reset release cannot masquerade as a rising edge
  assign frame_evt = q1_q & ~q2_q & arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
      arm_q   <= 1'b0;
      pre_q   <= 3'd0;
      div_q   <= 2'd0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      en_y_q  <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q1_q    <= vsync;
      q2_q    <= q1_q;
      arm_q   <= arm_q | ~vsync;
      pre_q   <= pre_d;
      div_q   <= div_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      en_y_q  <= en_y_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tick_q  <= frame_evt;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_wr) begin
      state_d = cmd;
    end else if (frame_evt && state_q == ST_STEP) begin
      state_d = ST_PAUSE;
    end
  end

  always_comb begin
    pre_max = (pre_q == ((3'd1 << div_q) - 3'd1));
    x_step  = dir_x_q ? (x_q - SX) : (x_q + SX);
    y_inc   = {1'b0, y_q} + SY;
    if (y_inc >= WRAP) y_inc = y_inc - WRAP;
    y_dec   = ({1'b0, y_q} >= SY) ? ({1'b0, y_q} - SY)
                                  : ({1'b0, y_q} + WRAP - SY);
    y_step  = y_q;
    if (en_y_q) y_step = dir_y_q ? y_dec[9:0] : y_inc[9:0];
  end

  always_comb begin
    do_step = 1'b0;
    pre_d   = pre_q;
    div_d   = div_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    en_y_d  = en_y_q;
    if (cfg_wr) begin
      div_d   = cfg_data[3:2];
      dir_x_d = cfg_data[4];
      dir_y_d = cfg_data[5];
      en_y_d  = cfg_data[6];
    end else if (frame_evt) begin
      case (state_q)
        ST_RUN: begin
          if (pre_max) begin
            do_step = 1'b1;
            pre_d   = 3'd0;
          end else begin
            pre_d = pre_q + 3'd1;
          end
        end
        ST_STEP: do_step = 1'b1;
        default: ;
      endcase
    end
    x_d = do_step ? x_step : x_q;
    y_d = do_step ? y_step : y_q;
    if (state_d == ST_STOP) begin
      x_d   = 10'd0;
      y_d   = 10'd0;
      pre_d = 3'd0;
    end
    run_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  assign scroll_x   = x_q;
  assign scroll_y   = y_q;
  assign frame_tick = tick_q;
  assign running    = run_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// tb_scroll_scheduler: directed and random frames checked against a
// frame-level behavioural model of the scroll offsets.
module tb_scroll_scheduler;
  localparam int VW = 480;
  localparam int SX = 1;
  localparam int SY = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic [9:0] scroll_x, scroll_y;
  logic       frame_tick, running;

  int n_chk = 0;
  int n_bad = 0;

  int m_mode, m_pre, m_div, m_dx, m_dy, m_ey;
  int m_x, m_y, m_tick, h_n;
  bit h_last, h_prev;

  always #5 clk = ~clk;

  scroll_scheduler #(.V_WRAP(VW), .STEP_X(SX), .STEP_Y(SY)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .cfg_wr(cfg_wr),
    .cfg_data(cfg_data),
    .scroll_x(scroll_x),
    .scroll_y(scroll_y),
    .frame_tick(frame_tick),
    .running(running)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_pre = 0; m_div = 0;
    m_dx = 0; m_dy = 0; m_ey = 0;
    m_x = 0; m_y = 0; m_tick = 0;
    h_n = 0; h_last = 0; h_prev = 0;
  endtask

  task automatic m_step();
    m_x = (m_x + (m_dx != 0 ? 1024 - SX : SX)) % 1024;
    if (m_ey != 0) m_y = (m_y + (m_dy != 0 ? VW - SY : SY)) % VW;
  endtask

  // frame event = a low sample followed by a high sample since reset
  task automatic m_edge();
    bit evt;
    evt = (h_n >= 2) && h_last && !h_prev;
    h_prev = h_last;
    h_last = vsync;
    h_n++;
    m_tick = evt;
    if (cfg_wr) begin
      m_mode = cfg_data[1:0];
      m_div  = cfg_data[3:2];
      m_dx   = cfg_data[4];
      m_dy   = cfg_data[5];
      m_ey   = cfg_data[6];
    end else if (evt) begin
      if (m_mode == 1) begin
        if (m_pre == (1 << m_div) - 1) begin
          m_step();
          m_pre = 0;
        end else begin
          m_pre++;
        end
      end else if (m_mode == 3) begin
        m_step();
        m_mode = 2;
      end
    end
    if (m_mode == 0) begin
      m_x = 0; m_y = 0; m_pre = 0;
    end
  endtask

  task automatic cyc(bit v, bit wr = 1'b0, logic [7:0] d = 8'h00);
    vsync = v; cfg_wr = wr; cfg_data = d;
    @(posedge clk);
    m_edge();
    #1;
    chk("x", scroll_x, m_x);
    chk("y", scroll_y, m_y);
    chk("tick", frame_tick, m_tick);
    chk("run", running, (m_mode == 1 || m_mode == 3) ? 1 : 0);
    cfg_wr = 1'b0;
  endtask

  task automatic frame(int hi, int lo, output int ticks, output int pos);
    ticks = 0; pos = 0;
    for (int i = 1; i <= hi + lo; i++) begin
      cyc(i <= hi);
      if (frame_tick) begin
        ticks++;
        pos = i;
      end
    end
  endtask

  task automatic frames(int n);
    int t, p;
    for (int i = 0; i < n; i++) frame(3, 3, t, p);
  endtask

  initial begin
    int t, p;
    bit v;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", scroll_x, 0);
    chk("rst_y", scroll_y, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_run", running, 0);
    rst_n = 1'b1;

    cyc(0, 1, 8'h01);
    for (int f = 1; f <= 3; f++) begin
      frame(3, 3, t, p);
      chk("r31_ticks", t, 1);
      chk("r31_pos", p, 2);
      chk("r31_x", scroll_x, f);
    end
    chk("r31_y", scroll_y, 0);

    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h4D);
    frames(7);
    chk("r32_x7", scroll_x, 0);
    frames(1);
    chk("r32_x8", scroll_x, 1);
    frames(8);
    chk("r32_x16", scroll_x, 2);
    chk("r32_y16", scroll_y, 2);

    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h71);
    frames(1);
    chk("wrap_x", scroll_x, 1023);
    chk("wrap_y", scroll_y, 479);
    cyc(0, 1, 8'h41);
    frames(1);
    chk("wrap_y0", scroll_y, 0);

    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h01);
    frames(5);
    chk("pre_step_x", scroll_x, 5);
    cyc(0, 1, 8'h03);
    chk("step_run", running, 1);
    frames(1);
    chk("step_x", scroll_x, 6);
    chk("step_run0", running, 0);
    frames(4);
    chk("pause_x", scroll_x, 6);

    cyc(1);
    cyc(1, 1, 8'h01);
    chk("coll_tick", frame_tick, 1);
    chk("coll_x", scroll_x, 6);
    cyc(1);
    repeat (3) cyc(0);
    frames(1);
    chk("coll_next_x", scroll_x, 7);
    cyc(0, 1, 8'h00);
    chk("stop_x", scroll_x, 0);
    chk("stop_y", scroll_y, 0);

    cyc(0, 1, 8'h01);
    for (int i = 0; i < 200; i++) frame(2, 2, t, p);
    chk("pre_rst_x", scroll_x, 200);
    vsync = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", scroll_x, 0);
    chk("arst_y", scroll_y, 0);
    chk("arst_tick", frame_tick, 0);
    chk("arst_run", running, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (frame_tick) t++;
    end
    chk("hi_rel_ticks", t, 0);
    cyc(0);
    frame(3, 3, t, p);
    chk("post_rel_ticks", t, 1);

    v = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) v = ~v;
      cyc(v, $urandom_range(0, 15) == 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
